// File: rtl/print_sequencer.sv
// Board-dump sequencer: pulls NCHARS characters from the board-to-text converter
// one at a time and hands each to the UART, with request queueing and abort.
module print_sequencer #(
    parameter int NCHARS = 589
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       print_req,
    input  logic       abort,
    input  logic [7:0] char_in,
    input  logic       tx_busy,
    output logic       processing,
    output logic       print_nxt,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       done
);

    typedef enum logic [3:0] {
        IDLE,
        ARM,
        REQ,
        CAPT,
        SEND,
        HOLD,
        WAITTX,
        NEXT,
        DONE
    } state_t;

    localparam logic [9:0] LAST = 10'(NCHARS - 1);

    state_t     state_q, state_d;
    logic [9:0] count_q, count_d;
    logic       pending_q, pending_d;
    logic [7:0] tx_data_q, tx_data_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            pending_q <= 1'b0;
            tx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            tx_data_q <= tx_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        pending_d  = pending_q;
        tx_data_d  = tx_data_q;
        print_nxt  = 1'b0;
        tx_start   = 1'b0;
        done       = 1'b0;
        busy       = (state_q != IDLE);
        processing = (state_q != IDLE) && (state_q != DONE) && !abort;

        // Load on the edge into SEND so the new byte is already on tx_data
        // during the first SEND cycle, where tx_start may fire.
        if (state_q == CAPT) begin
            tx_data_d = char_in;
        end

        if (abort) begin
            state_d   = IDLE;
            pending_d = 1'b0;
        end else begin
            if (print_req && busy) begin
                pending_d = 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (print_req || pending_q) begin
                        state_d   = ARM;
                        pending_d = 1'b0;
                    end
                end
                ARM: begin
                    count_d = '0;
                    state_d = REQ;
                end
                REQ: begin
                    print_nxt = 1'b1;
                    state_d   = CAPT;
                end
                CAPT: begin
                    state_d = SEND;
                end
                SEND: begin
                    if (!tx_busy) begin
                        tx_start = 1'b1;
                        state_d  = HOLD;
                    end
                end
                HOLD: begin
                    state_d = WAITTX;
                end
                WAITTX: begin
                    if (!tx_busy) begin
                        state_d = NEXT;
                    end
                end
                NEXT: begin
                    if (count_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        count_d = count_q + 10'd1;
                        state_d = REQ;
                    end
                end
                DONE: begin
                    done = 1'b1;
                    if (pending_q || print_req) begin
                        state_d   = ARM;
                        pending_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign tx_data = tx_data_q;

endmodule

// File: tb/tb_print_sequencer.sv
// Directed bench for print_sequencer with a converter model and a simple UART model.
module tb_print_sequencer;

    localparam int unsigned NCHARS = 589;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       print_req = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] char_in;
    logic       tx_busy;
    logic       processing;
    logic       print_nxt;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       busy;
    logic       done;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;

    always #5 clk = ~clk;

    print_sequencer #(.NCHARS(NCHARS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .print_req (print_req),
        .abort     (abort),
        .char_in   (char_in),
        .tx_busy   (tx_busy),
        .processing(processing),
        .print_nxt (print_nxt),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .busy      (busy),
        .done      (done)
    );

    function automatic logic [7:0] char_of(input int unsigned k);
        logic [15:0] v;
        v = 16'(k * 37 + 11);
        return v[7:0] ^ 8'(k >> 8);
    endfunction

    // Converter: next character appears the cycle after a print_nxt pulse.
    int unsigned conv_idx;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conv_idx <= 0;
            char_in  <= 8'h00;
        end else if (!processing) begin
            conv_idx <= 0;
        end else if (print_nxt) begin
            char_in  <= char_of(conv_idx);
            conv_idx <= conv_idx + 1;
        end
    end

    // UART: busy for one cycle per byte, or 50 cycles on the 10th byte when stalling.
    bit          stall_en = 1'b0;
    int unsigned busy_cnt;
    int unsigned uart_n;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt <= 0;
            uart_n   <= 0;
        end else begin
            if (tx_start) busy_cnt <= (stall_en && uart_n == 9) ? 50 : 1;
            else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
            if (!processing) uart_n <= 0;
            else if (tx_start) uart_n <= uart_n + 1;
        end
    end
    assign tx_busy = (busy_cnt != 0);

    // Monitor: samples outputs on the falling edge.
    int unsigned cyc = 0, nxt_cnt = 0, start_cnt = 0, done_cnt = 0;
    int unsigned order_errs = 0, hold_errs = 0, b2b_cnt = 0, tx_idx = 0;
    int unsigned last_arm_cyc = 0, last_done_cyc = 0;
    logic        proc_prev = 1'b0, done_prev = 1'b0;
    logic [7:0]  data_prev = 8'h00;
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (processing && !proc_prev) begin
            last_arm_cyc = cyc;
            tx_idx = 0;
            if (done_prev) b2b_cnt = b2b_cnt + 1;
        end
        if (print_nxt) nxt_cnt = nxt_cnt + 1;
        if (print_nxt && tx_busy) hold_errs = hold_errs + 1;
        if (tx_start) begin
            start_cnt = start_cnt + 1;
            if (tx_data !== char_of(tx_idx)) order_errs = order_errs + 1;
            tx_idx = tx_idx + 1;
            if (tx_busy) hold_errs = hold_errs + 1;
        end
        if (tx_busy && tx_data !== data_prev) hold_errs = hold_errs + 1;
        if (done) begin
            done_cnt = done_cnt + 1;
            last_done_cyc = cyc;
        end
        proc_prev = processing;
        done_prev = done;
        data_prev = tx_data;
    end

    task automatic pulse_req();
        @(negedge clk); #1 print_req = 1'b1;
        @(negedge clk); #1 print_req = 1'b0;
    endtask

    task automatic wait_done(input int unsigned target, input int unsigned max_cyc, output bit ok);
        ok = 1'b0;
        for (int unsigned i = 0; i < max_cyc; i++) begin
            @(negedge clk); #1;
            if (done_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        total_cnt++; if (processing !== 1'b0) $display("FAIL reset_processing: got %b expected 0", processing); else pass_cnt++;
        total_cnt++; if (print_nxt !== 1'b0) $display("FAIL reset_print_nxt: got %b expected 0", print_nxt); else pass_cnt++;
        total_cnt++; if (tx_start !== 1'b0) $display("FAIL reset_tx_start: got %b expected 0", tx_start); else pass_cnt++;
        total_cnt++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h expected 00", tx_data); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else pass_cnt++;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_release_idle: got %b expected 0", busy); else pass_cnt++;
    endtask

    task automatic test_single_dump();
        int unsigned s_nxt, s_start, s_done, s_ord;
        bit ok;
        s_nxt = nxt_cnt; s_start = start_cnt; s_done = done_cnt; s_ord = order_errs;
        pulse_req();
        wait_done(s_done + 1, 4000, ok);
        total_cnt++; if (ok !== 1'b1) $display("FAIL single_done_seen: got %b expected 1", ok); else pass_cnt++;
        total_cnt++; if (last_done_cyc - last_arm_cyc + 1 !== NCHARS * 6 + 2) $display("FAIL single_length: got %0d expected %0d", last_done_cyc - last_arm_cyc + 1, NCHARS * 6 + 2); else pass_cnt++;
        @(negedge clk); #1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL single_busy_after_done: got %b expected 0", busy); else pass_cnt++;
        total_cnt++; if (nxt_cnt - s_nxt !== NCHARS) $display("FAIL single_nxt_count: got %0d expected %0d", nxt_cnt - s_nxt, NCHARS); else pass_cnt++;
        total_cnt++; if (start_cnt - s_start !== NCHARS) $display("FAIL single_start_count: got %0d expected %0d", start_cnt - s_start, NCHARS); else pass_cnt++;
        total_cnt++; if (order_errs - s_ord !== 0) $display("FAIL single_order: got %0d errors expected 0", order_errs - s_ord); else pass_cnt++;
        total_cnt++; if (done_cnt - s_done !== 1) $display("FAIL single_done_count: got %0d expected 1", done_cnt - s_done); else pass_cnt++;
    endtask

    task automatic test_stall();
        int unsigned s_start, s_done, s_ord, s_hold;
        bit ok;
        s_start = start_cnt; s_done = done_cnt; s_ord = order_errs; s_hold = hold_errs;
        stall_en = 1'b1;
        pulse_req();
        wait_done(s_done + 1, 5000, ok);
        stall_en = 1'b0;
        total_cnt++; if (ok !== 1'b1) $display("FAIL stall_done_seen: got %b expected 1", ok); else pass_cnt++;
        total_cnt++; if (last_done_cyc - last_arm_cyc + 1 !== NCHARS * 6 + 2 + 49) $display("FAIL stall_length: got %0d expected %0d", last_done_cyc - last_arm_cyc + 1, NCHARS * 6 + 51); else pass_cnt++;
        total_cnt++; if (start_cnt - s_start !== NCHARS) $display("FAIL stall_start_count: got %0d expected %0d", start_cnt - s_start, NCHARS); else pass_cnt++;
        total_cnt++; if (order_errs - s_ord !== 0) $display("FAIL stall_order: got %0d errors expected 0", order_errs - s_ord); else pass_cnt++;
        total_cnt++; if (hold_errs - s_hold !== 0) $display("FAIL stall_holdoff: got %0d errors expected 0", hold_errs - s_hold); else pass_cnt++;
        @(negedge clk); #1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL stall_busy_after_done: got %b expected 0", busy); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int unsigned s_start, s_done, s_ord, s_b2b;
        bit ok;
        s_start = start_cnt; s_done = done_cnt; s_ord = order_errs; s_b2b = b2b_cnt;
        pulse_req();
        repeat (100) @(negedge clk);
        pulse_req();
        repeat (7) @(negedge clk);
        pulse_req();
        repeat (300) @(negedge clk);
        pulse_req();
        wait_done(s_done + 2, 8000, ok);
        total_cnt++; if (ok !== 1'b1) $display("FAIL queue_two_done_seen: got %b expected 1", ok); else pass_cnt++;
        repeat (20) @(negedge clk);
        #1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL queue_idle_after: got %b expected 0", busy); else pass_cnt++;
        total_cnt++; if (done_cnt - s_done !== 2) $display("FAIL queue_done_count: got %0d expected 2", done_cnt - s_done); else pass_cnt++;
        total_cnt++; if (start_cnt - s_start !== 2 * NCHARS) $display("FAIL queue_start_count: got %0d expected %0d", start_cnt - s_start, 2 * NCHARS); else pass_cnt++;
        total_cnt++; if (order_errs - s_ord !== 0) $display("FAIL queue_order: got %0d errors expected 0", order_errs - s_ord); else pass_cnt++;
        total_cnt++; if (b2b_cnt - s_b2b !== 1) $display("FAIL queue_arm_after_done: got %0d expected 1", b2b_cnt - s_b2b); else pass_cnt++;
    endtask

    task automatic test_abort();
        int unsigned s_start, s_done, s_ord, at_abort;
        bit ok;
        s_start = start_cnt; s_done = done_cnt;
        pulse_req();
        repeat (50) @(negedge clk);
        pulse_req();
        ok = 1'b0;
        for (int unsigned i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            if (start_cnt - s_start >= 300) begin
                ok = 1'b1;
                break;
            end
        end
        total_cnt++; if (ok !== 1'b1) $display("FAIL abort_reach_300: got %b expected 1", ok); else pass_cnt++;
        @(negedge clk); #1;
        abort = 1'b1;
        at_abort = start_cnt;
        @(negedge clk); #1;
        abort = 1'b0;
        total_cnt++; if (processing !== 1'b0) $display("FAIL abort_processing: got %b expected 0", processing); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy); else pass_cnt++;
        repeat (30) @(negedge clk);
        #1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL abort_pending_cleared: got %b expected 0", busy); else pass_cnt++;
        total_cnt++; if (done_cnt - s_done !== 0) $display("FAIL abort_no_done: got %0d expected 0", done_cnt - s_done); else pass_cnt++;
        total_cnt++; if (start_cnt !== at_abort) $display("FAIL abort_no_more_starts: got %0d expected %0d", start_cnt, at_abort); else pass_cnt++;
        s_start = start_cnt; s_ord = order_errs;
        pulse_req();
        wait_done(s_done + 1, 4000, ok);
        total_cnt++; if (ok !== 1'b1) $display("FAIL abort_redump_done: got %b expected 1", ok); else pass_cnt++;
        total_cnt++; if (start_cnt - s_start !== NCHARS) $display("FAIL abort_redump_count: got %0d expected %0d", start_cnt - s_start, NCHARS); else pass_cnt++;
        total_cnt++; if (order_errs - s_ord !== 0) $display("FAIL abort_redump_order: got %0d errors expected 0", order_errs - s_ord); else pass_cnt++;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_async_reset();
        bit ok;
        pulse_req();
        ok = 1'b0;
        for (int unsigned i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (tx_start) begin
                ok = 1'b1;
                break;
            end
        end
        total_cnt++; if (ok !== 1'b1) $display("FAIL areset_first_start: got %b expected 1", ok); else pass_cnt++;
        @(negedge clk); #1;
        @(negedge clk); #1;
        total_cnt++; if (busy !== 1'b1) $display("FAIL areset_pre_busy: got %b expected 1", busy); else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (processing !== 1'b0) $display("FAIL areset_processing: got %b expected 0", processing); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL areset_busy: got %b expected 0", busy); else pass_cnt++;
        total_cnt++; if (print_nxt !== 1'b0) $display("FAIL areset_print_nxt: got %b expected 0", print_nxt); else pass_cnt++;
        total_cnt++; if (tx_start !== 1'b0) $display("FAIL areset_tx_start: got %b expected 0", tx_start); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL areset_done: got %b expected 0", done); else pass_cnt++;
        total_cnt++; if (tx_data !== 8'h00) $display("FAIL areset_tx_data: got %h expected 00", tx_data); else pass_cnt++;
        @(negedge clk); #1;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL areset_idle_after: got %b expected 0", busy); else pass_cnt++;
    endtask

    task automatic test_abort_req_idle();
        @(negedge clk); #1;
        abort = 1'b1;
        print_req = 1'b1;
        @(negedge clk); #1;
        abort = 1'b0;
        print_req = 1'b0;
        total_cnt++; if (busy !== 1'b0) $display("FAIL idle_abort_req_busy: got %b expected 0", busy); else pass_cnt++;
        repeat (5) @(negedge clk);
        #1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL idle_abort_req_pending: got %b expected 0", busy); else pass_cnt++;
        total_cnt++; if (processing !== 1'b0) $display("FAIL idle_abort_req_processing: got %b expected 0", processing); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_dump();
        test_stall();
        test_back_to_back();
        test_abort();
        test_async_reset();
        test_abort_req_idle();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
